// File: rtl/bus_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one downstream bus master port among NUM_REQ requesters.
// Latency : request seen at edge N drives bus_ena from N+1; minimum three cycles per transfer.
// Backpressure: requesters hold until their req_ready pulse; a stalled bus is aborted after TIMEOUT cycles.
//
// Ports
//   i_clk, i_rst        clock (rising edge) and asynchronous active-high reset
//   i_req_ena           per-requester request, held until o_req_ready
//   i_req_wstb/addr/wdata  flattened per-requester fields, slice i = [(i+1)*W-1 : i*W]; wstb 0 = read
//   o_req_ready         one-hot completion pulse to the granted requester
//   o_req_rdata/slverr  broadcast response, valid with o_req_ready, held until the next response
//   o_bus_ena/wstb/addr/wdata  registered downstream transfer
//   i_bus_ready/rdata/slverr   downstream completion, only sampled while a transfer is in flight
//   o_grant_id          index of the current/last granted requester
//   o_busy              high from grant until the response cycle ends
module bus_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [NUM_REQ-1:0]                i_req_ena,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   i_req_wstb,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     i_req_wdata,
   output logic [NUM_REQ-1:0]                o_req_ready,
   output logic [DATA_WIDTH-1:0]             o_req_rdata,
   output logic                              o_req_slverr,
   output logic                              o_bus_ena,
   output logic [DATA_WIDTH/8-1:0]           o_bus_wstb,
   output logic [ADDR_WIDTH-1:0]             o_bus_addr,
   output logic [DATA_WIDTH-1:0]             o_bus_wdata,
   input  logic                              i_bus_ready,
   input  logic [DATA_WIDTH-1:0]             i_bus_rdata,
   input  logic                              i_bus_slverr,
   output logic [$clog2(NUM_REQ)-1:0]        o_grant_id,
   output logic                              o_busy
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ID_WIDTH   = $clog2(NUM_REQ);
   localparam int CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Value of the wait counter on the last BUSY cycle before an abort.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [ID_WIDTH-1:0]  ID_LAST  = ID_WIDTH'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   logic [ID_WIDTH-1:0]     r_ptr;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic [NUM_REQ-1:0]      r_req_ready;
   logic [DATA_WIDTH-1:0]   r_req_rdata;
   logic                    r_req_slverr;
   logic                    r_bus_ena;
   logic [STRB_WIDTH-1:0]   r_bus_wstb;
   logic [ADDR_WIDTH-1:0]   r_bus_addr;
   logic [DATA_WIDTH-1:0]   r_bus_wdata;
   logic [ID_WIDTH-1:0]     r_grant_id;
   logic                    r_busy;

   logic [STRB_WIDTH-1:0]   w_req_wstb  [NUM_REQ];
   logic [ADDR_WIDTH-1:0]   w_req_addr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]   w_req_wdata [NUM_REQ];
   logic                    w_found;
   logic [ID_WIDTH-1:0]     w_winner;
   logic [ID_WIDTH-1:0]     w_idx;
   logic                    w_timeout;
   logic [NUM_REQ-1:0]      w_ready_onehot;

   // Split the flattened request fields into per-requester views.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_wstb[gi]  = i_req_wstb[gi*STRB_WIDTH +: STRB_WIDTH];
      assign w_req_addr[gi]  = i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_req_wdata[gi] = i_req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin search: walk from the requester after the last winner,
   // wrapping at NUM_REQ-1, and take the first active request. The last
   // winner is visited last, so it only wins again when nobody else asks.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = r_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (w_idx == ID_LAST) ? '0 : w_idx + ID_WIDTH'(1);
         if (!w_found && i_req_ena[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // TIMEOUT of zero disables the abort path entirely.
   assign w_timeout      = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
   assign w_ready_onehot = NUM_REQ'(1) << r_grant_id;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_ptr        <= ID_LAST;
         r_cnt        <= '0;
         r_req_ready  <= '0;
         r_req_rdata  <= '0;
         r_req_slverr <= 1'b0;
         r_bus_ena    <= 1'b0;
         r_bus_wstb   <= '0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_grant_id   <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  // Latch the winner's fields; later changes on its inputs
                  // (including a dropped req_ena) no longer matter.
                  r_bus_ena   <= 1'b1;
                  r_bus_wstb  <= w_req_wstb[w_winner];
                  r_bus_addr  <= w_req_addr[w_winner];
                  r_bus_wdata <= w_req_wdata[w_winner];
                  r_grant_id  <= w_winner;
                  r_ptr       <= w_winner;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= S_BUSY;
               end
            end

            S_BUSY: begin
               // A real completion takes priority over an abort landing
               // on the same cycle.
               if (i_bus_ready) begin
                  r_bus_ena    <= 1'b0;
                  r_req_rdata  <= i_bus_rdata;
                  r_req_slverr <= i_bus_slverr;
                  r_req_ready  <= w_ready_onehot;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
                  if (w_timeout) begin
                     r_bus_ena    <= 1'b0;
                     r_req_rdata  <= '0;
                     r_req_slverr <= 1'b1;
                     r_req_ready  <= w_ready_onehot;
                     r_state      <= S_RESP;
                  end
               end
            end

            S_RESP: begin
               // One-cycle response pulse; new requests wait for IDLE.
               r_req_ready <= '0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_req_rdata  = r_req_rdata;
   assign o_req_slverr = r_req_slverr;
   assign o_bus_ena    = r_bus_ena;
   assign o_bus_wstb   = r_bus_wstb;
   assign o_bus_addr   = r_bus_addr;
   assign o_bus_wdata  = r_bus_wdata;
   assign o_grant_id   = r_grant_id;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Purpose : self-checking bench for bus_rr_arbiter (directed table, corner sequences, random traffic).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: bench acts as requesters (hold until served) and as the downstream responder.
module tb_bus_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int GW = $clog2(N);
   localparam int TO = 16;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_ena;
   logic [N*SW-1:0] req_wstb;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   req_rdata;
   logic            req_slverr;
   logic            bus_ena;
   logic [SW-1:0]   bus_wstb;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wdata;
   logic            bus_ready;
   logic [DW-1:0]   bus_rdata;
   logic            bus_slverr;
   logic [GW-1:0]   grant_id;
   logic            busy;

   // Per-requester fields, flattened onto the DUT inputs.
   logic [SW-1:0] f_wstb  [N];
   logic [AW-1:0] f_addr  [N];
   logic [DW-1:0] f_wdata [N];

   int            n_checks;
   int            n_errors;
   logic [GW-1:0] m_ptr;

   bus_rr_arbiter #(
      .NUM_REQ   (N),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT   (TO)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_ena   (req_ena),
      .i_req_wstb  (req_wstb),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_req_ready (req_ready),
      .o_req_rdata (req_rdata),
      .o_req_slverr(req_slverr),
      .o_bus_ena   (bus_ena),
      .o_bus_wstb  (bus_wstb),
      .o_bus_addr  (bus_addr),
      .o_bus_wdata (bus_wdata),
      .i_bus_ready (bus_ready),
      .i_bus_rdata (bus_rdata),
      .i_bus_slverr(bus_slverr),
      .o_grant_id  (grant_id),
      .o_busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      req_wstb  = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         req_wstb[i*SW +: SW]  = f_wstb[i];
         req_addr[i*AW +: AW]  = f_addr[i];
         req_wdata[i*DW +: DW] = f_wdata[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Next winner by the round-robin rule: first pending requester after the last one served.
   function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] pend, input logic [GW-1:0] last);
      for (int k = 1; k <= N; k++) begin
         int idx = (int'(last) + k) % N;
         if (pend[idx]) return GW'(idx);
      end
      return last;
   endfunction

   // One complete transfer. Called on a falling edge with req_ena already driven
   // (DUT idle); returns on the falling edge of the following IDLE cycle.
   // lat = number of BUSY cycles with bus_ready low before the responder answers.
   task automatic run_xfer(input logic [GW-1:0] exp_g, input int lat, input logic [DW-1:0] rd,
                           input logic se, input logic [DW-1:0] exp_rd, input logic exp_se,
                           input bit mutate, output logic [GW-1:0] obs_g);
      logic [SW-1:0] e_wstb;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      int            done_at;
      e_wstb  = f_wstb[exp_g];
      e_addr  = f_addr[exp_g];
      e_wdata = f_wdata[exp_g];
      done_at = (lat + 1 > TO) ? TO : lat + 1;
      // Stray responses while idle must be ignored.
      bus_ready  = 1'($urandom);
      bus_rdata  = $urandom;
      bus_slverr = 1'($urandom);
      @(negedge clk);
      obs_g = grant_id;
      chk("grant_id", 64'(grant_id), 64'(exp_g));
      chk("grant_busy", 64'(busy), 64'(1));
      chk("grant_ready_low", 64'(req_ready), 64'(0));
      chk("grant_wstb", 64'(bus_wstb), 64'(e_wstb));
      chk("grant_wdata", 64'(bus_wdata), 64'(e_wdata));
      for (int j = 1; j <= done_at; j++) begin
         chk("busy_ena", 64'(bus_ena), 64'(1));
         chk("busy_addr", 64'(bus_addr), 64'(e_addr));
         if (j == lat + 1) begin
            bus_ready  = 1'b1;
            bus_rdata  = rd;
            bus_slverr = se;
         end else begin
            bus_ready  = 1'b0;
            bus_rdata  = $urandom;
            bus_slverr = 1'($urandom);
         end
         if (mutate) begin
            f_addr[exp_g]  = $urandom;
            f_wdata[exp_g] = $urandom;
            f_wstb[exp_g]  = SW'($urandom);
            if ($urandom_range(0, 1) == 1) req_ena[exp_g] = 1'b0;
         end
         @(negedge clk);
      end
      chk("resp_ready", 64'(req_ready), 64'(N'(1) << exp_g));
      chk("resp_rdata", 64'(req_rdata), 64'(exp_rd));
      chk("resp_slverr", 64'(req_slverr), 64'(exp_se));
      chk("resp_ena_low", 64'(bus_ena), 64'(0));
      chk("resp_busy", 64'(busy), 64'(1));
      chk("resp_addr_held", 64'(bus_addr), 64'(e_addr));
      // Requester is served and withdraws; a late bus response must be discarded.
      req_ena[exp_g] = 1'b0;
      bus_ready      = 1'b1;
      bus_rdata      = $urandom;
      bus_slverr     = ~exp_se;
      @(negedge clk);
      chk("idle_ready_low", 64'(req_ready), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_rdata_held", 64'(req_rdata), 64'(exp_rd));
      chk("idle_slverr_held", 64'(req_slverr), 64'(exp_se));
      m_ptr = exp_g;
   endtask

   typedef struct {
      logic [N-1:0]  ena;
      int            lat;
      logic [DW-1:0] rd;
      logic          se;
      logic [GW-1:0] exp_g;
      logic [DW-1:0] exp_rd;
      logic          exp_se;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [GW-1:0] g;
      logic [N-1:0]  pend;
      int            waitc [N];
      int            lat;

      // Directed vectors; the arbiter pointer starts at N-1 and moves to each winner.
      tbl[0]  = '{4'b0001,  1, 32'h0000CAFE, 1'b0, 2'd0, 32'h0000CAFE, 1'b0}; // single read
      tbl[1]  = '{4'b1111,  0, 32'h00000011, 1'b0, 2'd1, 32'h00000011, 1'b0}; // all request
      tbl[2]  = '{4'b1111,  0, 32'h00000022, 1'b0, 2'd2, 32'h00000022, 1'b0};
      tbl[3]  = '{4'b1111,  0, 32'h00000033, 1'b1, 2'd3, 32'h00000033, 1'b1};
      tbl[4]  = '{4'b1111,  0, 32'h00000044, 1'b0, 2'd0, 32'h00000044, 1'b0}; // wraps
      tbl[5]  = '{4'b0100,  0, 32'h00000055, 1'b1, 2'd2, 32'h00000055, 1'b1}; // write, slverr
      tbl[6]  = '{4'b1010,  2, 32'h00000066, 1'b0, 2'd3, 32'h00000066, 1'b0};
      tbl[7]  = '{4'b1010,  3, 32'h00000077, 1'b0, 2'd1, 32'h00000077, 1'b0};
      tbl[8]  = '{4'b0001, 20, 32'h00000088, 1'b0, 2'd0, 32'h00000000, 1'b1}; // timeout
      tbl[9]  = '{4'b1000, 15, 32'h00001234, 1'b0, 2'd3, 32'h00001234, 1'b0}; // ready on abort cycle
      tbl[10] = '{4'b1000, 14, 32'h0000ABCD, 1'b1, 2'd3, 32'h0000ABCD, 1'b1}; // same requester again

      n_checks   = 0;
      n_errors   = 0;
      m_ptr      = GW'(N - 1);
      rst        = 1'b1;
      req_ena    = '0;
      bus_ready  = 1'b0;
      bus_rdata  = '0;
      bus_slverr = 1'b0;
      for (int i = 0; i < N; i++) begin
         f_wstb[i]  = '0;
         f_addr[i]  = AW'(32'h100 * (i + 1));
         f_wdata[i] = DW'(32'h1000 + i);
      end
      f_wstb[1]  = 4'h3;
      f_wstb[2]  = 4'hF;
      f_wdata[2] = 32'hDEADBEEF;

      repeat (2) @(negedge clk);
      chk("reset_ctrl", 64'({bus_ena, req_ready, grant_id, busy, req_slverr}), 64'(0));
      chk("reset_bus", 64'({bus_wstb, bus_addr}), 64'(0));
      chk("reset_data", {bus_wdata, req_rdata}, 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_req", 64'({bus_ena, busy}), 64'(0));

      for (int v = 0; v < NV; v++) begin
         req_ena = tbl[v].ena;
         run_xfer(tbl[v].exp_g, tbl[v].lat, tbl[v].rd, tbl[v].se, tbl[v].exp_rd, tbl[v].exp_se,
                  1'b0, g);
      end

      // Reset in the middle of a transfer: outputs clear at once, pointer restarts.
      req_ena   = 4'b0100;
      bus_ready = 1'b0;
      @(negedge clk);
      chk("rst_seq_ena", 64'(bus_ena), 64'(1));
      chk("rst_seq_addr", 64'(bus_addr), 64'(f_addr[2]));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_ctrl", 64'({bus_ena, req_ready, grant_id, busy, req_slverr}), 64'(0));
      chk("midrst_bus", 64'({bus_wstb, bus_addr}), 64'(0));
      chk("midrst_data", {bus_wdata, req_rdata}, 64'(0));
      @(negedge clk);
      rst     = 1'b0;
      req_ena = 4'b1111;
      run_xfer(2'd0, 0, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, g);
      req_ena = '0;

      // Random traffic against the round-robin reference.
      pend = '0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int t = 0; t < 250; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]    = 1'b1;
               f_addr[i]  = $urandom;
               f_wdata[i] = $urandom;
               f_wstb[i]  = SW'($urandom);
            end
         end
         req_ena = pend;
         if (pend == '0) begin
            bus_ready = 1'($urandom);
            @(negedge clk);
            chk("rand_idle", 64'({bus_ena, busy, req_ready}), 64'(0));
         end else begin
            logic [GW-1:0] exp_g;
            logic [DW-1:0] rd;
            logic          se;
            exp_g = rr_pick(pend, m_ptr);
            lat   = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            rd    = $urandom;
            se    = 1'($urandom);
            if (lat + 1 > TO)
               run_xfer(exp_g, lat, rd, se, '0, 1'b1, ($urandom_range(0, 3) == 0), g);
            else
               run_xfer(exp_g, lat, rd, se, rd, se, ($urandom_range(0, 3) == 0), g);
            for (int i = 0; i < N; i++) begin
               if (pend[i] && GW'(i) != g) waitc[i]++;
            end
            chk("fairness_wait", 64'(waitc[g] <= N - 1), 64'(1));
            waitc[g] = 0;
            pend[exp_g] = 1'b0;
            req_ena     = pend;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
